// File: rtl/lut_layer_scheduler_pkg.sv
// Shared types and constants for the LUT layer scheduler.
package lut_sched_pkg;

  typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

  localparam int unsigned FANIN       = 6;
  localparam int unsigned TT_DEPTH    = 64;
  localparam logic        CFG_SEL_TT  = 1'b0;
  localparam logic        CFG_SEL_IDX = 1'b1;

endpackage

// File: rtl/lut_layer_scheduler_if.sv
// Config, input-vector and result handshakes of the LUT layer scheduler.
interface lut_layer_scheduler_if #(
  parameter int unsigned IN_WIDTH    = 64,
  parameter int unsigned NUM_NEURONS = 32,
  parameter int unsigned IDX_W       = $clog2(IN_WIDTH),
  parameter int unsigned NRN_W       = $clog2(NUM_NEURONS)
);
  logic                   cfg_we;
  logic                   cfg_sel;
  logic [NRN_W-1:0]       cfg_neuron;
  logic [5:0]             cfg_addr;
  logic [IDX_W-1:0]       cfg_wdata;
  logic                   cfg_err;
  logic                   in_valid;
  logic                   in_ready;
  logic [IN_WIDTH-1:0]    in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [NUM_NEURONS-1:0] out_data;
  logic                   busy;

  modport master (
    output cfg_we, cfg_sel, cfg_neuron, cfg_addr, cfg_wdata, in_valid, in_data, out_ready,
    input  cfg_err, in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  cfg_we, cfg_sel, cfg_neuron, cfg_addr, cfg_wdata, in_valid, in_data, out_ready,
    output cfg_err, in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/lut_layer_scheduler_tt_bank.sv
// Truth-table and fan-in index storage: one write port, one combinational read.
module lut_tt_bank
  import lut_sched_pkg::*;
#(
  parameter int unsigned IN_WIDTH    = 64,
  parameter int unsigned NUM_NEURONS = 32,
  parameter int unsigned IDX_W       = $clog2(IN_WIDTH),
  parameter int unsigned NRN_W       = $clog2(NUM_NEURONS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we,
  input  logic                       sel,
  input  logic [NRN_W-1:0]           wr_neuron,
  input  logic [5:0]                 wr_addr,
  input  logic [IDX_W-1:0]           wr_data,
  input  logic [NRN_W-1:0]           rd_neuron,
  input  logic [FANIN-1:0]           rd_addr,
  output logic [FANIN-1:0][IDX_W-1:0] rd_idx,
  output logic                       rd_bit
);

  logic [TT_DEPTH-1:0]           tt_q  [NUM_NEURONS];
  logic [FANIN-1:0][IDX_W-1:0]   idx_q [NUM_NEURONS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned n = 0; n < NUM_NEURONS; n++) begin
        tt_q[n]  <= '0;
        idx_q[n] <= '0;
      end
    end else if (we) begin
      if (sel == CFG_SEL_TT) tt_q[wr_neuron][wr_addr] <= wr_data[0];
      else                   idx_q[wr_neuron][wr_addr[2:0]] <= wr_data;
    end
  end

  assign rd_idx = idx_q[rd_neuron];
  assign rd_bit = tt_q[rd_neuron][rd_addr];

endmodule

// File: rtl/lut_layer_scheduler.sv
// One-neuron-per-cycle evaluator for a layer of 6-input LUT neurons.
module lut_layer_scheduler
  import lut_sched_pkg::*;
#(
  parameter int unsigned IN_WIDTH    = 64,
  parameter int unsigned NUM_NEURONS = 32,
  parameter int unsigned IDX_W       = $clog2(IN_WIDTH),
  parameter int unsigned NRN_W       = $clog2(NUM_NEURONS)
) (
  input  logic                  clk,
  input  logic                  rst,
  lut_layer_scheduler_if.slave  bus
);

  state_t                     state_q;
  logic [NRN_W-1:0]           cnt_q;
  logic [IN_WIDTH-1:0]        in_reg_q;
  logic [NUM_NEURONS-1:0]     res_q;
  logic                       out_valid_q;
  logic                       busy_q;
  logic                       cfg_err_q;

  logic                       cfg_bad;
  logic                       cfg_commit;
  logic [FANIN-1:0][IDX_W-1:0] rd_idx;
  logic [FANIN-1:0]           eval_addr;
  logic                       rd_bit;
  logic                       cnt_last;

  // Neuron range is checked for both write kinds; slot/index range only for idx writes.
  assign cfg_bad = (32'(bus.cfg_neuron) >= NUM_NEURONS) ||
                   ((bus.cfg_sel == CFG_SEL_IDX) &&
                    ((bus.cfg_addr[2:0] > 3'(FANIN - 1)) || (32'(bus.cfg_wdata) >= IN_WIDTH)));
  assign cfg_commit = bus.cfg_we && (state_q == IDLE) && !cfg_bad;

  lut_tt_bank #(
    .IN_WIDTH    (IN_WIDTH),
    .NUM_NEURONS (NUM_NEURONS),
    .IDX_W       (IDX_W),
    .NRN_W       (NRN_W)
  ) u_bank (
    .clk       (clk),
    .rst       (rst),
    .we        (cfg_commit),
    .sel       (bus.cfg_sel),
    .wr_neuron (bus.cfg_neuron),
    .wr_addr   (bus.cfg_addr),
    .wr_data   (bus.cfg_wdata),
    .rd_neuron (cnt_q),
    .rd_addr   (eval_addr),
    .rd_idx    (rd_idx),
    .rd_bit    (rd_bit)
  );

  always_comb begin
    eval_addr = '0;
    for (int unsigned s = 0; s < FANIN; s++) eval_addr[s] = in_reg_q[rd_idx[s]];
  end

  assign cnt_last = (cnt_q == NRN_W'(NUM_NEURONS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      in_reg_q    <= '0;
      res_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      cfg_err_q <= bus.cfg_we && !cfg_commit;
      unique case (state_q)
        IDLE: if (bus.in_valid) begin
          in_reg_q <= bus.in_data;
          cnt_q    <= '0;
          busy_q   <= 1'b1;
          state_q  <= EVAL;
        end
        EVAL: begin
          res_q[cnt_q] <= rd_bit;
          cnt_q        <= cnt_q + 1'b1;
          if (cnt_last) begin
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: if (bus.out_ready) begin
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE) && !rst;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = res_q;
  assign bus.busy      = busy_q;
  assign bus.cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_lut_layer_scheduler.sv
// Randomized self-checking bench for lut_layer_scheduler against a truth-table model.
module tb_lut_layer_scheduler;

  localparam int unsigned W = 64;
  localparam int unsigned N = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lut_layer_scheduler_if #(.IN_WIDTH(W), .NUM_NEURONS(N)) bus ();

  lut_layer_scheduler #(.IN_WIDTH(W), .NUM_NEURONS(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  bit m_tt  [N][64];
  int m_idx [N][6];

  int nchecks = 0;
  int nerr    = 0;

  bit p_sel;
  int p_neu, p_addr, p_wd;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int n = 0; n < N; n++) begin
      for (int a = 0; a < 64; a++) m_tt[n][a] = 1'b0;
      for (int s = 0; s < 6; s++) m_idx[n][s] = 0;
    end
  endtask

  function automatic bit cfg_invalid(input bit sel, input int neu, input int addr, input int wd);
    return (neu >= N) || (sel && (((addr & 7) > 5) || (wd >= W)));
  endfunction

  task automatic model_write(input bit sel, input int neu, input int addr, input int wd);
    if (sel) m_idx[neu][addr & 7] = wd;
    else     m_tt[neu][addr] = wd[0];
  endtask

  function automatic logic [N-1:0] model_eval(input logic [W-1:0] v);
    logic [N-1:0] r;
    int a;
    for (int n = 0; n < N; n++) begin
      a = 0;
      for (int s = 0; s < 6; s++) if (v[m_idx[n][s]]) a += (1 << s);
      r[n] = m_tt[n][a];
    end
    return r;
  endfunction

  task automatic cfg_write(input bit sel, input int neu, input int addr, input int wd, input bit idle);
    bit bad;
    bad = !idle || cfg_invalid(sel, neu, addr, wd);
    @(negedge clk);
    bus.cfg_we     = 1'b1;
    bus.cfg_sel    = sel;
    bus.cfg_neuron = 5'(neu);
    bus.cfg_addr   = 6'(addr);
    bus.cfg_wdata  = 6'(wd);
    @(posedge clk);
    if (!bad) model_write(sel, neu, addr, wd);
    @(negedge clk);
    bus.cfg_we = 1'b0;
    check("cfg_err", 64'(bus.cfg_err), 64'(bad));
  endtask

  task automatic run_vector(input logic [W-1:0] v, input int hold, input bit cfg_in_done, input bit pend);
    logic [N-1:0] exp;
    bit pbad;
    int k;
    pbad = cfg_invalid(p_sel, p_neu, p_addr, p_wd);
    @(negedge clk);
    check("in_ready_idle", 64'(bus.in_ready), 64'd1);
    bus.in_data  = v;
    bus.in_valid = 1'b1;
    if (pend) begin
      bus.cfg_we     = 1'b1;
      bus.cfg_sel    = p_sel;
      bus.cfg_neuron = 5'(p_neu);
      bus.cfg_addr   = 6'(p_addr);
      bus.cfg_wdata  = 6'(p_wd);
    end
    @(posedge clk);
    if (pend && !pbad) model_write(p_sel, p_neu, p_addr, p_wd);
    exp = model_eval(v);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.cfg_we   = 1'b0;
    if (pend) check("cfg_err_same_cycle", 64'(bus.cfg_err), 64'(pbad));
    check("busy_eval", 64'(bus.busy), 64'd1);
    k = 0;
    while (!bus.out_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("latency", 64'(k), 64'(N));
    check("out_data", 64'(bus.out_data), 64'(exp));
    check("in_ready_done", 64'(bus.in_ready), 64'd0);
    for (int i = 0; i < hold; i++) begin
      if (cfg_in_done && i == 2)
        cfg_write(1'b0, $urandom_range(0, N - 1), $urandom_range(0, 63), 1, 1'b0);
      @(negedge clk);
      check("hold_valid", 64'(bus.out_valid), 64'd1);
      check("hold_data", 64'(bus.out_data), 64'(exp));
      check("hold_in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("valid_after_accept", 64'(bus.out_valid), 64'd0);
    check("busy_after_accept", 64'(bus.busy), 64'd0);
    check("in_ready_after_accept", 64'(bus.in_ready), 64'd1);
    check("data_kept", 64'(bus.out_data), 64'(exp));
  endtask

  initial begin
    logic [W-1:0] v;
    bus.cfg_we = 1'b0; bus.cfg_sel = 1'b0; bus.cfg_neuron = '0; bus.cfg_addr = '0;
    bus.cfg_wdata = '0; bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    p_sel = 1'b0; p_neu = 0; p_addr = 0; p_wd = 0;
    model_clear();

    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_cfg_err", 64'(bus.cfg_err), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_out_data", 64'(bus.out_data), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // unconfigured layer evaluates to all zeros
    v = {$urandom, $urandom};
    run_vector(v, 0, 1'b0, 1'b0);
    check("unconfigured_zero", 64'(bus.out_data), 64'd0);

    // neuron 0 as 6-input AND over inputs 0..5
    cfg_write(1'b0, 0, 63, 1, 1'b1);
    for (int s = 0; s < 6; s++) cfg_write(1'b1, 0, s, s, 1'b1);
    run_vector(64'h3F, 0, 1'b0, 1'b0);
    check("and6_hit", 64'(bus.out_data[0]), 64'd1);
    run_vector(64'h1F, 1, 1'b0, 1'b0);
    check("and6_miss", 64'(bus.out_data[0]), 64'd0);

    // neuron 31 as parity over the top six inputs
    for (int a = 0; a < 64; a++) cfg_write(1'b0, 31, a, $countones(a) & 1, 1'b1);
    for (int s = 0; s < 6; s++) cfg_write(1'b1, 31, s, 63 - s, 1'b1);
    run_vector(64'h8000_0000_0000_0000, 0, 1'b0, 1'b0);
    check("parity_msb", 64'(bus.out_data[31]), 64'd1);

    // long stall in DONE with a rejected config write
    run_vector({$urandom, $urandom}, 10, 1'b1, 1'b0);

    // out-of-range fan-in slots are rejected and leave the old wiring
    cfg_write(1'b1, 0, 6, 9, 1'b1);
    cfg_write(1'b1, 0, 7, 9, 1'b1);
    run_vector(64'h3F, 0, 1'b0, 1'b0);
    check("and6_after_bad_idx", 64'(bus.out_data[0]), 64'd1);

    // config write and vector accept in the same cycle
    p_sel = 1'b0; p_neu = 0; p_addr = 6'h1F; p_wd = 1;
    run_vector(64'h1F, 0, 1'b0, 1'b1);
    check("same_cycle_cfg_used", 64'(bus.out_data[0]), 64'd1);

    // reset in the middle of an evaluation
    @(negedge clk);
    bus.in_data = {$urandom, $urandom};
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_in_ready", 64'(bus.in_ready), 64'd0);
    check("midrst_out_data", 64'(bus.out_data), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    run_vector({$urandom, $urandom}, 0, 1'b0, 1'b0);
    run_vector(64'h3F, 0, 1'b0, 1'b0);
    check("tables_cleared", 64'(bus.out_data), 64'd0);

    // randomized configuration and vectors
    for (int it = 0; it < 20; it++) begin
      for (int c = 0; c < 12; c++) begin
        if ($urandom_range(0, 1) == 1)
          cfg_write(1'b1, $urandom_range(0, N - 1), $urandom_range(0, 7), $urandom_range(0, W - 1), 1'b1);
        else
          cfg_write(1'b0, $urandom_range(0, N - 1), $urandom_range(0, 63), $urandom_range(0, 1), 1'b1);
      end
      p_sel  = 1'($urandom_range(0, 1));
      p_neu  = $urandom_range(0, N - 1);
      p_addr = $urandom_range(0, 63);
      p_wd   = $urandom_range(0, W - 1);
      run_vector({$urandom, $urandom}, $urandom_range(0, 3), 1'b0, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
